// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the memory-port bridge state type.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    RD_ADDR,
    RD_DATA
  } bridge_state_e;

endpackage

// File: rtl/axi_master_mem_bridge.sv
// Bridges a req/gnt/r_valid memory port onto single-beat AXI4 transactions,
// one transaction outstanding at a time.
module axi_master_mem_bridge
  import axi_pkg::*;
#(
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_USER_WIDTH = 10,
  parameter int ADDR_LSB       = $clog2(AXI_STRB_WIDTH),
  parameter int AXI_ID         = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      data_req_i,
  input  logic [AXI_ADDR_WIDTH-1:0] data_add_i,
  input  logic                      data_wen_i,
  input  logic [AXI_DATA_WIDTH-1:0] data_wdata_i,
  input  logic [AXI_STRB_WIDTH-1:0] data_be_i,
  output logic                      data_gnt_o,
  output logic                      data_r_valid_o,
  output logic [AXI_DATA_WIDTH-1:0] data_r_rdata_o,
  output logic                      data_err_o,
  output logic [AXI_ID_WIDTH-1:0]   awid,
  output logic [AXI_ADDR_WIDTH-1:0] awaddr,
  output logic [7:0]                awlen,
  output logic [2:0]                awsize,
  output logic [1:0]                awburst,
  output logic                      awlock,
  output logic [3:0]                awcache,
  output logic [2:0]                awprot,
  output logic [3:0]                awregion,
  output logic [3:0]                awqos,
  output logic [AXI_USER_WIDTH-1:0] awuser,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [AXI_DATA_WIDTH-1:0] wdata,
  output logic [AXI_STRB_WIDTH-1:0] wstrb,
  output logic                      wlast,
  output logic [AXI_USER_WIDTH-1:0] wuser,
  output logic                      wvalid,
  input  logic                      wready,
  input  logic [AXI_ID_WIDTH-1:0]   bid,
  input  logic [1:0]                bresp,
  input  logic [AXI_USER_WIDTH-1:0] buser,
  input  logic                      bvalid,
  output logic                      bready,
  output logic [AXI_ID_WIDTH-1:0]   arid,
  output logic [AXI_ADDR_WIDTH-1:0] araddr,
  output logic [7:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic                      arlock,
  output logic [3:0]                arcache,
  output logic [2:0]                arprot,
  output logic [3:0]                arregion,
  output logic [3:0]                arqos,
  output logic [AXI_USER_WIDTH-1:0] aruser,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [AXI_ID_WIDTH-1:0]   rid,
  input  logic [AXI_DATA_WIDTH-1:0] rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic [AXI_USER_WIDTH-1:0] ruser,
  input  logic                      rvalid,
  output logic                      rready
);

  bridge_state_e state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [AXI_STRB_WIDTH-1:0] be_q;
  logic                      aw_done_q, w_done_q;
  logic                      r_valid_q, err_q;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;
  logic                      aw_fire, w_fire, b_fire, r_fire;
  logic                      unused_inputs;

  assign aw_fire = awvalid & awready;
  assign w_fire  = wvalid & wready;
  assign b_fire  = bvalid & bready;
  assign r_fire  = rvalid & rready;

  assign awid     = AXI_ID_WIDTH'(AXI_ID);
  assign awaddr   = addr_q;
  assign awlen    = 8'd0;
  assign awsize   = 3'(ADDR_LSB);
  assign awburst  = BURST_INCR;
  assign awlock   = 1'b0;
  assign awcache  = 4'd0;
  assign awprot   = 3'd0;
  assign awregion = 4'd0;
  assign awqos    = 4'd0;
  assign awuser   = '0;
  assign wdata    = wdata_q;
  assign wstrb    = be_q;
  assign wlast    = wvalid;
  assign wuser    = '0;
  assign arid     = AXI_ID_WIDTH'(AXI_ID);
  assign araddr   = addr_q;
  assign arlen    = 8'd0;
  assign arsize   = 3'(ADDR_LSB);
  assign arburst  = BURST_INCR;
  assign arlock   = 1'b0;
  assign arcache  = 4'd0;
  assign arprot   = 3'd0;
  assign arregion = 4'd0;
  assign arqos    = 4'd0;
  assign aruser   = '0;

  assign data_r_valid_o = r_valid_q;
  assign data_r_rdata_o = rdata_q;
  assign data_err_o     = err_q;

  // IDs, user fields, rlast and the low resp bit carry no meaning for a single-beat master.
  assign unused_inputs = ^{bid, buser, bresp[0], rid, ruser, rresp[0], rlast};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      r_valid_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_valid_q <= 1'b0;
      if (data_gnt_o) begin
        addr_q    <= data_add_i << ADDR_LSB;
        wdata_q   <= data_wdata_i;
        be_q      <= data_be_i;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (aw_fire) aw_done_q <= 1'b1;
      if (w_fire)  w_done_q  <= 1'b1;
      if (b_fire) begin
        r_valid_q <= 1'b1;
        rdata_q   <= '0;
        err_q     <= bresp[1];
      end
      if (r_fire) begin
        r_valid_q <= 1'b1;
        rdata_q   <= rdata;
        err_q     <= rresp[1];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    data_gnt_o = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    unique case (state_q)
      IDLE: begin
        data_gnt_o = data_req_i & ~reset;
        if (data_gnt_o) state_d = data_wen_i ? WRITE : RD_ADDR;
      end
      WRITE: begin
        // AW and W complete independently; leave once both have handshaken.
        awvalid = ~aw_done_q;
        wvalid  = ~w_done_q;
        if ((aw_done_q | aw_fire) && (w_done_q | w_fire)) state_d = WRESP;
      end
      WRESP: begin
        bready = 1'b1;
        if (bvalid) state_d = IDLE;
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
